// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction fetch engine with a small prefetch FIFO.
// Drives a one-cycle-latency instruction memory, buffers {fetch address, word} pairs,
// and hands them to decode under a valid/deq handshake. Branch redirects flush all state.
module fetch_prefetch_queue #(
    parameter int unsigned ADDRESS_LEN = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          branch_taken,
    input  logic [ADDRESS_LEN-1:0]        branch_addr,
    input  logic                          deq,
    output logic                          mem_rd_en,
    output logic [ADDRESS_LEN-1:0]        mem_addr,
    input  logic [ADDRESS_LEN-1:0]        mem_rdata,
    output logic                          valid,
    output logic [ADDRESS_LEN-1:0]        pc,
    output logic [ADDRESS_LEN-1:0]        instruction,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDRESS_LEN-1:0] fetch_addr;
    logic                   inflight;
    logic [ADDRESS_LEN-1:0] inflight_tag;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [ADDRESS_LEN-1:0] addr_q  [DEPTH];
    logic [ADDRESS_LEN-1:0] instr_q [DEPTH];

    logic [CNT_W-1:0]       credits_used;
    logic                   push;
    logic                   pop;

    // Issue control: credit counts queued entries plus the read still in flight;
    // a same-cycle pop is deliberately not credited.
    always_comb begin
        credits_used = count + CNT_W'(inflight);
        mem_rd_en    = !rst && !branch_taken && (credits_used < CNT_W'(DEPTH));
        mem_addr     = fetch_addr;
        push         = inflight && !rst && !branch_taken;
        pop          = deq && valid && !rst && !branch_taken;
    end

    // Fetch pointer, in-flight tracking and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr   <= '0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else if (branch_taken) begin
            fetch_addr   <= {branch_addr[ADDRESS_LEN-1:2], 2'b00};
            inflight     <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            if (mem_rd_en) begin
                fetch_addr   <= fetch_addr + ADDRESS_LEN'(4);
                inflight     <= 1'b1;
                inflight_tag <= fetch_addr;
            end else begin
                inflight     <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage: capture the returning word with its address tag.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr]  <= inflight_tag;
            instr_q[wr_ptr] <= mem_rdata;
        end
    end

    // Head presentation; an empty queue shows the all-zero NOP.
    always_comb begin
        valid       = (count != '0);
        pc          = '0;
        instruction = '0;
        if (valid) begin
            pc          = addr_q[rd_ptr] + ADDRESS_LEN'(4);
            instruction = instr_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed stimulus with a queue-based reference model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_fetch_prefetch_queue;

    localparam int unsigned AL    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          branch_taken = 1'b0;
    logic [AL-1:0] branch_addr = '0;
    logic          deq = 1'b0;
    logic          mem_rd_en;
    logic [AL-1:0] mem_addr;
    logic [AL-1:0] mem_rdata = '0;
    logic          valid;
    logic [AL-1:0] pc;
    logic [AL-1:0] instruction;
    logic [CW-1:0] count;

    int vectors     = 0;
    int miscompares = 0;

    logic [AL-1:0] mem_xor = '0;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.ADDRESS_LEN(AL), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .deq          (deq),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .valid        (valid),
        .pc           (pc),
        .instruction  (instruction),
        .count        (count)
    );

    // Synchronous instruction memory: word = address ^ mem_xor, junk when not read.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? (mem_addr ^ mem_xor) : 32'h0BAD_F00D;
    end

    // Reference model: queue of delivered pairs plus one pending request.
    logic [AL-1:0] qa[$];
    logic [AL-1:0] qd[$];
    bit            pend = 1'b0;
    logic [AL-1:0] pend_a = '0;
    logic [AL-1:0] pend_d = '0;
    logic [AL-1:0] m_fetch = '0;
    bit            started = 1'b0;

    always @(posedge clk) begin
        bit issue;
        issue = !rst && !branch_taken && ((qa.size() + int'(pend)) < int'(DEPTH));
        if (rst) begin
            qa.delete();
            qd.delete();
            pend    = 1'b0;
            m_fetch = '0;
            started = 1'b1;
        end else if (branch_taken) begin
            qa.delete();
            qd.delete();
            pend    = 1'b0;
            m_fetch = branch_addr & ~32'h3;
        end else begin
            if (deq && qa.size() > 0) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (pend) begin
                qa.push_back(pend_a);
                qd.push_back(pend_d);
            end
            if (issue) begin
                pend    = 1'b1;
                pend_a  = m_fetch;
                pend_d  = m_fetch ^ mem_xor;
                m_fetch = m_fetch + 32'd4;
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            logic          e_en;
            logic          e_valid;
            logic [AL-1:0] e_pc;
            logic [AL-1:0] e_instr;
            logic [CW-1:0] e_count;
            e_en    = !rst && !branch_taken && ((qa.size() + int'(pend)) < int'(DEPTH));
            e_valid = (qa.size() != 0);
            e_pc    = e_valid ? qa[0] + 32'd4 : '0;
            e_instr = e_valid ? qd[0] : '0;
            e_count = CW'(qa.size());
            vectors++;
            if (mem_rd_en !== e_en || mem_addr !== m_fetch || valid !== e_valid ||
                pc !== e_pc || instruction !== e_instr || count !== e_count) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t en %b/%b addr %h/%h valid %b/%b pc %h/%h instr %h/%h count %0d/%0d (actual/required)",
                         $time, mem_rd_en, e_en, mem_addr, m_fetch, valid, e_valid,
                         pc, e_pc, instruction, e_instr, count, e_count);
            end
        end
    end

    task automatic chk(input string name, input logic [AL-1:0] act, input logic [AL-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One cycle: apply inputs just after the edge, return at the following negedge.
    task automatic cyc(input logic r, input logic b, input logic [AL-1:0] ba, input logic d);
        @(posedge clk);
        #1;
        rst          = r;
        branch_taken = b;
        branch_addr  = ba;
        deq          = d;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        // Fill with deq held low: four issues then stall
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("fill_en0", 32'(mem_rd_en), 32'd1);
        chk("fill_addr0", mem_addr, 32'h0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("fill_addr1", mem_addr, 32'h4);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("fill_addr2", mem_addr, 32'h8);
        chk("fill_valid_c2", 32'(valid), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("fill_addr3", mem_addr, 32'hC);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("fill_stall_en", 32'(mem_rd_en), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_pc", pc, 32'h4);
        chk("fill_instr", instruction, 32'h0);

        // Pop from full: issue resumes the cycle after the pop
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("full_pop_en", 32'(mem_rd_en), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("after_pop_count", 32'(count), 32'd3);
        chk("after_pop_en", 32'(mem_rd_en), 32'd1);
        chk("after_pop_addr", mem_addr, 32'h10);
        chk("after_pop_pc", pc, 32'h8);

        // Branch to 0x103 while full with one read in flight
        cyc(1'b0, 1'b1, 32'h103, 1'b0);
        chk("br_pre_count", 32'(count), 32'd3);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("br1_count", 32'(count), 32'd0);
        chk("br1_valid", 32'(valid), 32'd0);
        chk("br1_en", 32'(mem_rd_en), 32'd1);
        chk("br1_addr", mem_addr, 32'h100);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("br2_valid", 32'(valid), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("br3_pc", pc, 32'h104);
        chk("br3_instr", instruction, 32'h100);
        chk("br3_count", 32'(count), 32'd1);

        // Streaming with deq every cycle, new memory pattern
        mem_xor = 32'hDEAD_BEEF;
        cyc(1'b1, 1'b0, '0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            if (k < 2) begin
                chk("stream_valid_early", 32'(valid), 32'd0);
            end else begin
                chk("stream_valid", 32'(valid), 32'd1);
                chk("stream_pc", pc, 32'(4 * (k - 1)));
                chk("stream_instr", instruction, 32'(4 * (k - 2)) ^ 32'hDEAD_BEEF);
            end
        end

        // Branch together with deq and a returning response
        cyc(1'b0, 1'b1, 32'h200, 1'b1);
        chk("brdeq_pre_count", 32'(count), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("brdeq1_count", 32'(count), 32'd0);
        chk("brdeq1_valid", 32'(valid), 32'd0);
        chk("brdeq1_addr", mem_addr, 32'h200);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("brdeq2_valid", 32'(valid), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("brdeq3_pc", pc, 32'h204);
        chk("brdeq3_instr", instruction, 32'h200 ^ 32'hDEAD_BEEF);

        // Address wrap at the top of memory
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_addr1", mem_addr, 32'hFFFF_FFF8);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_addr2", mem_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_addr3", mem_addr, 32'h0000_0000);
        chk("wrap_pc1", pc, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_pc2", pc, 32'h0000_0000);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_pc3", pc, 32'h0000_0004);

        // Reset mid-stream with three entries queued
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, '0, 1'b0);
        end
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("midrst_pre_count", 32'(count), 32'd3);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("midrst1_count", 32'(count), 32'd0);
        chk("midrst1_valid", 32'(valid), 32'd0);
        chk("midrst1_pc", pc, 32'd0);
        chk("midrst1_instr", instruction, 32'd0);
        chk("midrst1_en", 32'(mem_rd_en), 32'd1);
        chk("midrst1_addr", mem_addr, 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("midrst2_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("midrst3_count", 32'(count), 32'd1);
        chk("midrst3_pc", pc, 32'h4);
        chk("midrst3_instr", instruction, 32'h0 ^ 32'hDEAD_BEEF);

        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
